// File: rtl/pc_ras_unit.sv
// Program counter with a return-address stack for zero-latency predicted returns.
// Define RAS_OVERFLOW_WRAP_EN to overwrite the oldest entry on a push into a full stack.
module pc_ras_unit #(
    parameter int                PC_W       = 32,
    parameter int                INC        = 2,
    parameter logic [PC_W-1:0]   START_ADDR = {PC_W{1'b0}},
    parameter int                RAS_DEPTH  = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            branch_wb_i,
    input  logic [PC_W-1:0] wb_pc_i,
    input  logic            take_branch_i,
    input  logic [PC_W-1:0] branch_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [PC_W-1:0] program_counter_o,
    output logic            is_valid_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ras_ovf_o
);

    localparam int              PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(RAS_DEPTH);
    localparam logic [PC_W-1:0] INC_C      = PC_W'(INC);
    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-1){1'b1}}, 1'b0};

    logic [PC_W-1:0]  pc_r;
    logic             valid_r;
    logic [PTR_W-1:0] ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             empty_r;
    logic             full_r;
    logic [PC_W-1:0]  ras_mem_r [RAS_DEPTH];

    logic [PTR_W-1:0] top_idx_s;
    logic [PC_W-1:0]  ras_top_s;
    logic [PC_W-1:0]  pc_inc_s;
    logic             stack_empty_s;
    logic             stack_full_s;
    logic             push_s;
    logic             pop_s;
    logic [PC_W-1:0]  pc_nxt_s;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;
    logic             wr_en_s;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Stack top lookup and push/pop qualification
    always_comb begin
        top_idx_s     = ptr_r - PTR_W'(1);
        ras_top_s     = ras_mem_r[top_idx_s];
        pc_inc_s      = pc_r + INC_C;
        stack_empty_s = (cnt_r == {CNT_W{1'b0}});
        stack_full_s  = (cnt_r == DEPTH_C);
        push_s        = take_branch_i && call_i && !stall_i && !branch_wb_i;
        pop_s         = ret_i && !take_branch_i && !stall_i && !branch_wb_i && !stack_empty_s;
    end

    // Next-PC selection in priority order
    always_comb begin
        pc_nxt_s = pc_r;
        if (stall_i) begin
            pc_nxt_s = pc_r;
        end else if (branch_wb_i) begin
            pc_nxt_s = align_pc(wb_pc_i);
        end else if (take_branch_i) begin
            pc_nxt_s = align_pc(branch_pc_i);
        end else if (ret_i && !stack_empty_s) begin
            pc_nxt_s = align_pc(ras_top_s);
        end else begin
            pc_nxt_s = pc_inc_s;
        end
    end

    // Stack pointer, occupancy and overflow update
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = ovf_r;
        wr_en_s   = 1'b0;
        if (push_s) begin
            if (stack_full_s) begin
                ovf_nxt_s = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
                // ptr_r points at the oldest entry when full
                wr_en_s   = 1'b1;
                ptr_nxt_s = ptr_r + PTR_W'(1);
`else
                wr_en_s   = 1'b0;
`endif
            end else begin
                wr_en_s   = 1'b1;
                ptr_nxt_s = ptr_r + PTR_W'(1);
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else if (pop_s) begin
            ptr_nxt_s = ptr_r - PTR_W'(1);
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_r    <= START_ADDR;
            valid_r <= 1'b0;
            ptr_r   <= {PTR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            valid_r <= 1'b1;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
            empty_r <= (cnt_nxt_s == {CNT_W{1'b0}});
            full_r  <= (cnt_nxt_s == DEPTH_C);
        end
    end

    // Stack entry storage; contents are don't-care after reset
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_en_s) begin
            ras_mem_r[ptr_r] <= pc_inc_s;
        end
    end

    assign program_counter_o = pc_r;
    assign is_valid_o        = valid_r;
    assign ras_empty_o       = empty_r;
    assign ras_full_o        = full_r;
    assign ras_ovf_o         = ras_ovf_r_alias();

    function automatic logic ras_ovf_r_alias();
        return ovf_r;
    endfunction

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios plus random traffic
// against a queue-based model of the PC and return-address stack.
module tb_pc_ras_unit;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_wb_i = 1'b0;
    logic [31:0] wb_pc_i = 32'h0;
    logic        take_branch_i = 1'b0;
    logic [31:0] branch_pc_i = 32'h0;
    logic        call_i = 1'b0;
    logic        ret_i = 1'b0;
    logic [31:0] program_counter_o;
    logic        is_valid_o;
    logic        ras_empty_o;
    logic        ras_full_o;
    logic        ras_ovf_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] pc_m = 32'h0;
    logic        valid_m = 1'b0;
    logic        ovf_m = 1'b0;
    logic [31:0] ras_q [$];

    pc_ras_unit #(.PC_W(32), .INC(2), .START_ADDR(32'h0), .RAS_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i),
        .branch_wb_i(branch_wb_i), .wb_pc_i(wb_pc_i),
        .take_branch_i(take_branch_i), .branch_pc_i(branch_pc_i),
        .call_i(call_i), .ret_i(ret_i),
        .program_counter_o(program_counter_o), .is_valid_o(is_valid_o),
        .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ras_ovf_o(ras_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: the stack is a queue, newest entry at the back.
    task automatic model_push(input logic [31:0] v);
        if (ras_q.size() == DEPTH) begin
            ovf_m = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
            void'(ras_q.pop_front());
            ras_q.push_back(v);
`endif
        end else begin
            ras_q.push_back(v);
        end
    endtask

    task automatic model_update(input logic rst, stl, wb, tb, cl, rt,
                                input logic [31:0] wpc, bpc);
        if (rst) begin
            pc_m = 32'h0; valid_m = 1'b0; ovf_m = 1'b0; ras_q.delete();
        end else begin
            valid_m = 1'b1;
            if (stl) begin
                pc_m = pc_m;
            end else if (wb) begin
                pc_m = wpc & ~32'h1;
            end else if (tb) begin
                if (cl) model_push(pc_m + 32'h2);
                pc_m = bpc & ~32'h1;
            end else if (rt && ras_q.size() > 0) begin
                pc_m = ras_q.pop_back() & ~32'h1;
            end else begin
                pc_m = pc_m + 32'h2;
            end
        end
    endtask

    task automatic step(input logic rst, stl, wb, tb, cl, rt,
                        input logic [31:0] wpc, bpc);
        reset_i = rst; stall_i = stl; branch_wb_i = wb; take_branch_i = tb;
        call_i = cl; ret_i = rt; wb_pc_i = wpc; branch_pc_i = bpc;
        model_update(rst, stl, wb, tb, cl, rt, wpc, bpc);
        @(posedge clk_i);
        #1;
        chk("pc", program_counter_o, pc_m);
        chk("valid", {31'b0, is_valid_o}, {31'b0, valid_m});
        chk("empty", {31'b0, ras_empty_o}, {31'b0, ras_q.size() == 0});
        chk("full", {31'b0, ras_full_o}, {31'b0, ras_q.size() == DEPTH});
        chk("ovf", {31'b0, ras_ovf_o}, {31'b0, ovf_m});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask
    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask
    task automatic redirect(input logic [31:0] a);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 32'h0);
    endtask
    task automatic call(input logic [31:0] a);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, a);
    endtask
    task automatic ret();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] pc_before;
        // Reset then four sequential fetches
        do_reset();
        chk("reset_pc", program_counter_o, 32'h0);
        chk("reset_valid", {31'b0, is_valid_o}, 32'h0);
        chk("reset_empty", {31'b0, ras_empty_o}, 32'h1);
        for (int i = 0; i < 4; i++) idle();
        chk("seq_pc8", program_counter_o, 32'h8);
        chk("seq_valid", {31'b0, is_valid_o}, 32'h1);

        // Call then return
        redirect(32'h100);
        call(32'h400);
        chk("call_pc", program_counter_o, 32'h400);
        ret();
        chk("ret_pc", program_counter_o, 32'h102);
        chk("ret_empty", {31'b0, ras_empty_o}, 32'h1);

        // Writeback redirect beats branch and return and leaves the stack alone
        call(32'h200);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h81, 32'h300);
        chk("wb_pc", program_counter_o, 32'h80);
        ret();
        chk("wb_ras_kept", program_counter_o, 32'h104);

        // Nine calls into an eight-entry stack, then eight returns
        do_reset();
        for (int i = 1; i <= 9; i++) call(32'h1000 * i);
        chk("ovf_set", {31'b0, ras_ovf_o}, 32'h1);
        chk("full_set", {31'b0, ras_full_o}, 32'h1);
        for (int i = 0; i < 8; i++) ret();
        chk("ovf_sticky", {31'b0, ras_ovf_o}, 32'h1);

        // Stall with a call held; then return on an empty stack
        do_reset();
        call(32'h500);
        pc_before = program_counter_o;
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h900);
        chk("stall_pc", program_counter_o, pc_before);
        ret();
        pc_before = program_counter_o;
        ret();
        chk("ret_empty_inc", program_counter_o, pc_before + 32'h2);

        // Reset while stalled with three entries pushed
        call(32'h600); call(32'h700); call(32'h800);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
        chk("rst_stall_pc", program_counter_o, 32'h0);
        chk("rst_stall_empty", {31'b0, ras_empty_o}, 32'h1);
        chk("rst_stall_ovf", {31'b0, ras_ovf_o}, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom(), $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
